// File: rtl/aqed_top_mul_arb_pkg.sv
// Shared widths, counter helper and output-stage state encoding for the
// arbitrated signed multiplier.
package aqed_top_mul_arb_pkg;

    localparam int DEF_A_W = 15;
    localparam int DEF_B_W = 8;
    localparam int DEF_P_W = DEF_A_W + DEF_B_W;
    localparam int CNT_W   = 16;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/aqed_top_mul_mul_eOg.sv
// Combinational multiplier: unsigned din0 times two's-complement din1,
// producing an exact signed product.
module aqed_top_mul_mul_eOg #(
    parameter int din0_WIDTH = 15,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 23
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic signed [dout_WIDTH-1:0] a_ext_s;
    logic signed [dout_WIDTH-1:0] b_ext_s;

    // Zero-extend A, sign-extend B; the true product always fits dout_WIDTH.
    always_comb begin
        a_ext_s = dout_WIDTH'($signed({1'b0, din0}));
        b_ext_s = dout_WIDTH'($signed(din1));
        dout    = a_ext_s * b_ext_s;
    end

endmodule

// File: rtl/aqed_top_mul_arb.sv
// Round-robin arbiter feeding one shared multiplier into a single-entry
// output register with valid/ready handshake and per-requester counters.
module aqed_top_mul_arb
    import aqed_top_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*A_W-1:0]           req_a,
    input  logic [NUM_REQ*B_W-1:0]           req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [P_W-1:0]                   rsp_p,
    output logic [NUM_REQ*CNT_W-1:0]         grant_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    ostate_e          state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  gnt_idx_s;
    logic             gnt_found_s;
    logic             accept_s;
    int               idx_s;
    logic [A_W-1:0]   opa_s;
    logic [B_W-1:0]   opb_s;
    logic [P_W-1:0]   prod_s;
    logic [ID_W-1:0]  rsp_id_q;
    logic [P_W-1:0]   rsp_p_q;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        idx_s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = int'(rr_q) + k;
            idx_s = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
            if (!gnt_found_s && req_valid[idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = ID_W'(idx_s);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign accept_s = ap_rst_n && gnt_found_s &&
                      ((state_q == ST_EMPTY) || rsp_ready);

    // One-hot ready for the granted requester, only when an accept happens.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Priority moves to the requester after the one just served.
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            rr_d = (int'(gnt_idx_s) == NUM_REQ - 1) ? '0 : gnt_idx_s + ID_W'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    assign opa_s = req_a[gnt_idx_s*A_W +: A_W];
    assign opb_s = req_b[gnt_idx_s*B_W +: B_W];

    aqed_top_mul_mul_eOg #(
        .din0_WIDTH (A_W),
        .din1_WIDTH (B_W),
        .dout_WIDTH (P_W)
    ) u_mul (
        .din0 (opa_s),
        .din1 (opb_s),
        .dout (prod_s)
    );

    // Output-stage state register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-stage next state: a coinciding drain and accept stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = accept_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output-stage outputs.
    always_comb begin
        rsp_id = rsp_id_q;
        rsp_p  = rsp_p_q;
        case (state_q)
            ST_EMPTY: rsp_valid = 1'b0;
            ST_FULL:  rsp_valid = 1'b1;
            default:  rsp_valid = 1'b0;
        endcase
    end

    // Pointer and held response; payload only changes on an accept.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rr_q     <= '0;
            rsp_id_q <= '0;
            rsp_p_q  <= '0;
        end else if (accept_s) begin
            rr_q     <= rr_d;
            rsp_id_q <= gnt_idx_s;
            rsp_p_q  <= prod_s;
        end else begin
            rr_q     <= rr_d;
            rsp_id_q <= rsp_id_q;
            rsp_p_q  <= rsp_p_q;
        end
    end

    // Saturating per-requester accept counters.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s && (int'(gnt_idx_s) == i)) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_aqed_top_mul_arb.sv
// Directed and randomized bench for aqed_top_mul_arb against a queue-free
// behavioural model of arbitration, product and counters.
module tb_aqed_top_mul_arb;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int BW = 8;
    localparam int PW = 23;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [0:0]      rsp_id;
    logic [PW-1:0]   rsp_p;
    logic [N*16-1:0] grant_cnt;

    int passed = 0;
    int total  = 0;

    // behavioural model state
    int            m_rr;
    bit            m_full;
    logic [PW-1:0] m_p;
    int            m_id;
    int            m_cnt [N];
    int            m_last_gnt;

    aqed_top_mul_arb #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic signed [31:0] av;
        logic signed [31:0] bv;
        logic signed [31:0] pr;
        av = $signed({17'd0, a});
        bv = 32'($signed(b));
        pr = av * bv;
        return pr[PW-1:0];
    endfunction

    function automatic int model_grant();
        int idx;
        if (!rst_n) return -1;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_full = 1'b0; m_p = '0; m_id = 0; m_last_gnt = -1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: check ready mid-cycle, advance model at the edge, check outputs after it.
    task automatic tick(input string tag);
        int g;
        logic [N-1:0] exp_ready;
        logic [N*16-1:0] exp_cnt;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        m_last_gnt = g;
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_full = 1'b1;
            m_id   = g;
            m_p    = ref_prod(req_a[g*AW +: AW], req_b[g*BW +: BW]);
            m_rr   = (g + 1) % N;
            if (m_cnt[g] < 65535) m_cnt[g] = m_cnt[g] + 1;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
        for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
        check({tag, "_valid"}, 64'(rsp_valid), 64'(m_full));
        check({tag, "_id"},    64'(rsp_id),    64'(m_id));
        check({tag, "_p"},     64'(rsp_p),     64'(m_p));
        check({tag, "_cnt"},   64'(grant_cnt), 64'(exp_cnt));
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_valid[i]        = v;
        req_a[i*AW +: AW]   = a;
        req_b[i*BW +: BW]   = b;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '1; req_a = '1; req_b = '1;

        // reset state, with requests pending: nothing may be accepted
        tick("rst0");
        tick("rst1");
        check("rst_p_zero", 64'(rsp_p), 64'd0);
        rst_n = 1'b1; req_valid = '0;
        tick("idle");

        // single request, largest A times most negative B
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 15'd32767, 8'h80);
        tick("r032");
        check("r032_const_p", 64'(rsp_p), 64'(23'h400080));
        set_req(0, 1'b0, 15'd0, 8'd0);
        tick("r032_drain");

        // sign corners from requester 1
        set_req(1, 1'b1, 15'd1, 8'hFF);
        tick("r033a");
        check("r033a_const_p", 64'(rsp_p), 64'(23'h7FFFFF));
        check("r033a_const_id", 64'(rsp_id), 64'd1);
        set_req(1, 1'b1, 15'd0, 8'h80);
        tick("r033b");
        check("r033b_const_p", 64'(rsp_p), 64'd0);
        set_req(1, 1'b0, 15'd0, 8'd0);
        tick("r033_drain");

        // contention from a clean pointer/counter state
        rst_n = 1'b0;
        tick("r034_rst");
        rst_n = 1'b1;
        set_req(0, 1'b1, 15'd100, 8'd3);
        set_req(1, 1'b1, 15'd200, 8'hFD);
        for (int i = 0; i < 6; i++) begin
            tick("r034");
            check("r034_const_id", 64'(rsp_id), 64'(i % 2));
        end
        check("r034_const_cnt", 64'(grant_cnt), 64'h0003_0003);
        req_valid = '0;
        tick("r034_drain");

        // backpressure: one accept then hold, then drain+accept with no bubble
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 15'(2 * $urandom_range(0, 16383)), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            tick("r035_stall");
            set_req(0, 1'b1, 15'($urandom), 8'($urandom));
        end
        check("r035_const_cnt0", 64'(grant_cnt[15:0]), 64'd4);
        rsp_ready = 1'b1;
        tick("r035_release");
        check("r035_const_valid", 64'(rsp_valid), 64'd1);
        check("r035_const_cnt1", 64'(grant_cnt[15:0]), 64'd5);
        req_valid = '0;
        tick("r035_drain");

        // reset while FULL: held product discarded
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 15'd1234, 8'd77);
        tick("r036_fill");
        req_valid = '0;
        rst_n = 1'b0;
        tick("r036_rst");
        check("r036_const_valid", 64'(rsp_valid), 64'd0);
        check("r036_const_cnt", 64'(grant_cnt), 64'd0);
        rst_n = 1'b1; rsp_ready = 1'b1;
        tick("r036_after");
        check("r036_const_after", 64'(rsp_valid), 64'd0);

        // randomized traffic; requesters hold valid and data until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && m_last_gnt != i))
                    set_req(i, 1'($urandom_range(0, 2) != 0), 15'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 60) != 0);
            tick("rand");
        end
        rst_n = 1'b1;

        // counter saturation
        rst_n = 1'b0; req_valid = '0;
        tick("r037_rst");
        rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(0, 1'b1, 15'd3, 8'd5);
        for (int c = 0; c < 65540; c++) tick("r037");
        check("r037_const_sat", 64'(grant_cnt[15:0]), 64'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
